instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage feeding the decode/register-file stage: holds the PC, issues word fetches to instruction
//  memory over a req/ack handshake, and delivers {pc, instruction} pairs to decode through a 2-entry queue
//  with valid/ready flow control. Redirects the PC on a taken branch and discards stale fetches.
// PARAMETERS
//  XLEN      64             PC / address width
//  ILEN      32             instruction width
//  RESET_PC  64'h0          first fetch address after reset
//  NOP_INSN  32'h00000013   value driven on fetch_instruction when queue empty
// PORTS
//  clk                input   1     clock, all state on rising edge
//  reset              input   1     asynchronous, active-high reset
//  branch_taken       input   1     redirect pulse, 1 cycle
//  branch_target      input   XLEN  redirect address, sampled with branch_taken
//  imem_req           output  1     fetch request, held until imem_ack
//  imem_addr          output  XLEN  fetch address, stable while imem_req=1
//  imem_ack           input   1     1-cycle response pulse; imem_rdata valid same cycle
//  imem_rdata         input   ILEN  fetched instruction
//  fetch_valid        output  1     queue head valid toward decode
//  fetch_pc           output  XLEN  PC of queue head
//  fetch_instruction  output  ILEN  instruction of queue head
//  id_ready           input   1     decode accepts head this cycle (transfer = fetch_valid & id_ready)
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, state=IDLE, queue empty, imem_req=0, imem_addr=RESET_PC, fetch_valid=0,
//    fetch_pc=0, fetch_instruction=NOP_INSN. Outputs are registered or decoded from registers only.
//  - States: IDLE, REQ, DRAIN, STALL.
//    IDLE: req=0; next REQ (one-cycle bubble after reset).
//    REQ: req=1, addr=pc. On ack: push {pc, rdata} to queue, pc<=pc+4; next REQ if queue occupancy after
//      this cycle's push/pop <=1, else STALL.
//    STALL: req=0; next REQ when occupancy after this cycle's pop <=1 (guarantees a slot for the response).
//    DRAIN: req=1, addr unchanged; on ack discard rdata, next REQ with pc already = redirect target.
//  - Redirect (branch_taken=1): queue flushed (fetch_valid=0 next cycle, a same-cycle pop is still a valid
//    transfer); pc<={branch_target[XLEN-1:2],2'b00}. If in REQ with no ack this cycle -> DRAIN. If ack in the
//    same cycle -> response discarded, next REQ. From IDLE/STALL -> REQ. Redirect in DRAIN: update pc, stay.
//  - Request stability: once imem_req rises, imem_req and imem_addr do not change until the ack cycle.
//  - imem_ack while imem_req=0 is ignored (covers acks arriving after reset).
//  - Queue: 2-entry FIFO, in-order; simultaneous push and pop allowed at any occupancy incl. 2 (no push at 2
//    by construction). Never overflows; assertion on push when full.
//  - PC arithmetic modulo 2^XLEN; pc+4 at 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
//  - Latency: ack cycle -> fetch_valid=1 next cycle. Zero-stall throughput: one instruction per 2 cycles
//    with 1-cycle memory (req cycle, ack cycle back-to-back re-request allowed: REQ->REQ on ack).
//  - Reset mid-operation: all state cleared immediately; imem_req deasserts asynchronously.
// STRUCTURE
//  - Shared pipeline package: XLEN, ILEN, NOP_INSN constant, fetch state enum {IDLE,REQ,DRAIN,STALL},
//    fetch bundle typedef {pc, instruction}.
//  - One sub-module: fetch_queue (2-entry FIFO of fetch bundles, push/pop/flush, count output).
//  - FSM, PC register and redirect logic stay in this module.
// TESTING
//  1. Reset then id_ready=1, memory acks 1 cycle after req with rdata=addr[31:0]^32'hA5A5A5A5 ->
//     fetch_pc sequence 0,4,8,12 with matching instructions, no gaps beyond the IDLE bubble.
//  2. id_ready=0 for 10 cycles -> queue fills to 2, state STALL, imem_req=0; release -> pc 0,4 delivered
//     in order, then fetch resumes at 8.
//  3. branch_taken with target 64'h1002 while request to 0x10 is outstanding (ack 3 cycles later) ->
//     DRAIN, response for 0x10 discarded, next imem_addr=0x1000, fetch_valid=0 until 0x1000 arrives.
//  4. branch_taken in same cycle as ack for 0x8 -> 0x8 never appears on fetch_pc; next fetch at target.
//  5. Async reset pulse mid-REQ, then stray imem_ack after reset -> imem_req=0 immediately, ack ignored,
//     first fetch_pc after reset = RESET_PC.
//  6. RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 -> fetch_pc sequence ...FFF8, ...FFFC, 0, 4.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, NOP encoding, FSM states and the queued bundle.
package instruction_fetch_unit_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSN   = 32'h00000013;
  localparam logic [XLEN-1:0] INSN_BYTES = 64'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    STALL
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instruction;
  } fetch_bundle_t;

  // Branch targets are forced onto a word boundary before they reach the PC.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_queue.sv
// Two-entry in-order FIFO of fetch bundles between the fetch FSM and decode.
// Slot 0 is always the head; a pop shifts slot 1 down.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_bundle_t push_data,
  input  logic          pop,
  output fetch_bundle_t head,
  output logic [1:0]    count
);

  fetch_bundle_t slot0;
  fetch_bundle_t slot1;
  logic          pop_eff;
  logic [1:0]    wr_slot;

  assign pop_eff = pop && (count != 2'd0);
  assign wr_slot = count - {1'b0, pop_eff};
  assign head    = slot0;

  // Shift on pop, then write the incoming bundle behind whatever remains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (pop_eff) begin
        slot0 <= slot1;
      end
      if (push) begin
        if (wr_slot == 2'd0) begin
          slot0 <= push_data;
        end else begin
          slot1 <= push_data;
        end
      end
      count <= count + {1'b0, push} - {1'b0, pop_eff};
    end
  end

  // The fetch FSM only requests when a slot is guaranteed, so a push into a full queue is a bug.
  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop_eff && (count == 2'd2)));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, imem req/ack FSM, branch redirect, and a 2-entry queue toward decode.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [ILEN-1:0] fetch_instruction,
  input  logic            id_ready
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] addr_q;
  logic            push;
  logic            pop;
  logic [1:0]      q_count;
  logic [1:0]      occ_next;
  fetch_bundle_t   q_head;
  fetch_bundle_t   push_data;

  // A response is only kept when it belongs to a live REQ and no redirect lands in the same cycle.
  assign push      = (state == REQ) && imem_ack && !branch_taken;
  assign pop       = (q_count != 2'd0) && id_ready;
  assign occ_next  = q_count + {1'b0, push} - {1'b0, pop};
  assign push_data = '{pc: pc, instruction: imem_rdata};

  fetch_queue u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (branch_taken),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count)
  );

  // State, PC and the issued address; the address freezes while a stale request drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      addr_q <= (state_next == DRAIN) ? addr_q : pc_next;
    end
  end

  // Next PC: redirect wins, otherwise advance one word on an accepted response.
  always_comb begin
    pc_next = pc;
    if (branch_taken) begin
      pc_next = align_word(branch_target);
    end else if ((state == REQ) && imem_ack) begin
      pc_next = pc + INSN_BYTES;
    end
  end

  // Next state: only request again when the queue will have room for the answer.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (branch_taken) begin
          state_next = imem_ack ? REQ : DRAIN;
        end else if (imem_ack) begin
          state_next = (occ_next <= 2'd1) ? REQ : STALL;
        end
      end
      STALL: begin
        if (branch_taken || (occ_next <= 2'd1)) begin
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded purely from registered state and queue contents.
  always_comb begin
    imem_req          = (state == REQ) || (state == DRAIN);
    imem_addr         = addr_q;
    fetch_valid       = (q_count != 2'd0);
    fetch_pc          = '0;
    fetch_instruction = NOP_INSN;
    if (q_count != 2'd0) begin
      fetch_pc          = q_head.pc;
      fetch_instruction = q_head.instruction;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a transaction-level model of the fetch stream.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [31:0] SALT    = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [63:0] fetch_pc;
  logic [31:0] fetch_instruction;
  logic        id_ready;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [63:0] w_pc;
  logic [31:0] w_insn;
  logic        w_ready;

  int checks = 0;
  int errors = 0;

  fetch_bundle_t exp_q[$];
  logic [63:0]   model_pc;
  bit            discard;
  bit            prev_req;
  bit            prev_ack;
  logic [63:0]   prev_addr;
  int            mem_wait;
  int            mem_delay;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .fetch_valid       (fetch_valid),
    .fetch_pc          (fetch_pc),
    .fetch_instruction (fetch_instruction),
    .id_ready          (id_ready)
  );

  instruction_fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk               (clk),
    .reset             (reset),
    .branch_taken      (1'b0),
    .branch_target     (64'd0),
    .imem_req          (w_req),
    .imem_addr         (w_addr),
    .imem_ack          (w_ack),
    .imem_rdata        (w_rdata),
    .fetch_valid       (w_valid),
    .fetch_pc          (w_pc),
    .fetch_instruction (w_insn),
    .id_ready          (w_ready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    case ($urandom_range(0, 3))
      0:       t = {$urandom(), $urandom()};
      1:       t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      2:       t = 64'h1002;
      default: t = 64'($urandom_range(0, 255));
    endcase
    return t;
  endfunction

  task automatic reset_model(input logic [63:0] start_pc);
    exp_q.delete();
    model_pc  = start_pc;
    discard   = 1'b0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    mem_wait  = 0;
    mem_delay = 0;
  endtask

  // One negedge per cycle: check outputs against the model, drive inputs, advance the model.
  task automatic applyStimulus(input int cycles, input int ready_pct, input int branch_pct,
                               input int delay_max);
    for (int i = 0; i < cycles; i++) begin
      fetch_bundle_t nb;
      bit            xfer;
      bit            accepted;
      @(negedge clk);
      checkOutput("fetch_valid", fetch_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        checkOutput("fetch_pc", fetch_pc, exp_q[0].pc);
        checkOutput("fetch_insn", fetch_instruction, exp_q[0].instruction);
      end else begin
        checkOutput("empty_insn", fetch_instruction, NOP_INSN);
      end
      checkOutput("imem_req_room", imem_req, exp_q.size() <= 1);
      if (imem_req && !discard) checkOutput("imem_addr", imem_addr, model_pc);
      if (prev_req && !prev_ack) begin
        checkOutput("req_hold", imem_req, 1'b1);
        checkOutput("addr_hold", imem_addr, prev_addr);
      end

      id_ready      = ($urandom_range(0, 99) < ready_pct);
      branch_taken  = ($urandom_range(0, 99) < branch_pct);
      branch_target = pick_target();
      if (imem_ack) begin
        imem_ack  = 1'b0;
        mem_wait  = 0;
        mem_delay = $urandom_range(0, delay_max);
      end else if (imem_req) begin
        if (mem_wait >= mem_delay) imem_ack = 1'b1;
        else mem_wait++;
      end else begin
        mem_wait = 0;
      end
      imem_rdata = imem_ack ? (imem_addr[31:0] ^ SALT) : $urandom();

      xfer     = (exp_q.size() != 0) && id_ready;
      accepted = imem_req && imem_ack;
      if (xfer) void'(exp_q.pop_front());
      if (accepted) begin
        if (discard || branch_taken) begin
          discard = 1'b0;
        end else begin
          nb.pc          = model_pc;
          nb.instruction = model_pc[31:0] ^ SALT;
          exp_q.push_back(nb);
          model_pc = model_pc + 64'd4;
        end
      end
      if (branch_taken) begin
        exp_q.delete();
        model_pc = {branch_target[63:2], 2'b00};
        if (imem_req && !imem_ack) discard = 1'b1;
      end
      if (exp_q.size() > 2) checkOutput("queue_bound", 64'(exp_q.size()), 64'd2);

      prev_req  = imem_req;
      prev_addr = imem_addr;
      prev_ack  = imem_ack;
    end
  endtask

  // Second instance starts near the top of the address space and must wrap cleanly.
  initial begin
    logic [63:0] want_pc;
    int          seen;
    w_ack   = 1'b0;
    w_rdata = '0;
    w_ready = 1'b1;
    seen    = 0;
    #1;
    wait (reset === 1'b0);
    for (int c = 0; c < 40 && seen < 4; c++) begin
      @(negedge clk);
      if (w_valid) begin
        want_pc = WRAP_PC + 64'(4 * seen);
        checkOutput("wrap_pc", w_pc, want_pc);
        checkOutput("wrap_insn", w_insn, want_pc[31:0] ^ SALT);
        seen++;
      end
      w_ack   = w_req && !w_ack;
      w_rdata = w_addr[31:0] ^ SALT;
    end
    checkOutput("wrap_count", 64'(seen), 64'd4);
    w_ack = 1'b0;
  end

  initial begin
    reset         = 1'b1;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    id_ready      = 1'b0;
    reset_model(64'd0);
    repeat (3) @(negedge clk);
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_addr", imem_addr, 64'd0);
    checkOutput("rst_valid", fetch_valid, 1'b0);
    checkOutput("rst_pc", fetch_pc, 64'd0);
    checkOutput("rst_insn", fetch_instruction, NOP_INSN);
    #1 reset = 1'b0;

    $display("[TB] streaming with 1-cycle memory");
    applyStimulus(20, 100, 0, 0);
    $display("[TB] decode backpressure");
    applyStimulus(10, 0, 0, 0);
    applyStimulus(12, 100, 0, 0);
    $display("[TB] random traffic with redirects");
    applyStimulus(3000, 60, 8, 3);

    $display("[TB] async reset mid-operation");
    @(negedge clk);
    branch_taken = 1'b0;
    id_ready     = 1'b0;
    imem_ack     = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_req", imem_req, 1'b0);
    checkOutput("midrst_valid", fetch_valid, 1'b0);
    checkOutput("midrst_addr", imem_addr, 64'd0);
    checkOutput("midrst_insn", fetch_instruction, NOP_INSN);
    repeat (2) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    reset_model(64'd0);
    #1 reset = 1'b0;
    applyStimulus(300, 70, 5, 2);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
